// File: rtl/lsu_multicycle_if.sv
// Request and bus bundle of the multicycle load/store unit.
// The slave modport is the LSU itself; the master modport is the requester and memory side.
interface lsu_multicycle_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              i_req;
    logic              i_we;
    logic [2:0]        i_mode;
    logic [ADDR_W-1:0] i_addr;
    logic [XLEN-1:0]   i_wdata;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic [XLEN-1:0]   o_rdata;
    logic              o_bus_valid;
    logic              o_bus_we;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [XLEN-1:0]   o_bus_wdata;
    logic [XLEN/8-1:0] o_bus_be;
    logic              i_bus_ready;
    logic [XLEN-1:0]   i_bus_rdata;

    modport slave (
        input  i_req, i_we, i_mode, i_addr, i_wdata, i_bus_ready, i_bus_rdata,
        output o_busy, o_done, o_err, o_rdata,
        output o_bus_valid, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be
    );

    modport master (
        output i_req, i_we, i_mode, i_addr, i_wdata, i_bus_ready, i_bus_rdata,
        input  o_busy, o_done, o_err, o_rdata,
        input  o_bus_valid, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be
    );
endinterface

// File: rtl/lsu_multicycle.sv
// Multicycle load/store unit: one aligned RV-style access per request over a simple valid/ready bus.
// Define LSU_TIMEOUT_EN to abort a bus access with an error after TIMEOUT cycles without ready.
//
// state  | meaning
// S_IDLE | waiting for i_req; request fields are latched on acceptance
// S_BUS  | o_bus_valid high, waiting for i_bus_ready (or timeout)
// S_DONE | one-cycle completion pulse, o_err qualifies it
module lsu_multicycle #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic            clk,
    input logic            rst,
    lsu_multicycle_if.slave lsu
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    if (!(XLEN == 32 || XLEN == 64) || TIMEOUT < 1) begin : g_bad_cfg
        $error("lsu_multicycle: XLEN must be 32 or 64 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_legal, req_aligned, bus_valid;
    logic [OFFW-1:0]   off;
    logic [NB-1:0]     be_base;
    logic [XLEN-1:0]   rd_shift, rd_ext;

    function automatic logic [3:0] size_of(input logic [2:0] m);
        return 4'd1 << m[1:0];
    endfunction

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        req_legal = 1'b0;
        case (lsu.i_mode)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !lsu.i_we;
            3'b011:                 req_legal = (XLEN == 64);
            3'b110:                 req_legal = (XLEN == 64) && !lsu.i_we;
            default:                req_legal = 1'b0;
        endcase
    end

    assign req_aligned = (lsu.i_addr[3:0] & (size_of(lsu.i_mode) - 4'd1)) == 4'd0;

    assign off = addr_q[OFFW-1:0];

    always_comb begin
        be_base = '0;
        for (int i = 0; i < NB; i++) be_base[i] = (i < int'(size_of(mode_q)));
    end

    // Load lane extraction; W/WU only reachable with a full 32-bit slice present.
    assign rd_shift = lsu.i_bus_rdata >> {off, 3'b000};
    always_comb begin
        rd_ext = rd_shift;
        case (mode_q)
            3'b000:  rd_ext = XLEN'($signed(rd_shift[7:0]));
            3'b001:  rd_ext = XLEN'($signed(rd_shift[15:0]));
            3'b010:  rd_ext = XLEN'($signed(rd_shift[31:0]));
            3'b100:  rd_ext = XLEN'(rd_shift[7:0]);
            3'b101:  rd_ext = XLEN'(rd_shift[15:0]);
            3'b110:  rd_ext = XLEN'(rd_shift[31:0]);
            default: rd_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (lsu.i_req) begin
                    we_d    = lsu.i_we;
                    mode_d  = lsu.i_mode;
                    addr_d  = lsu.i_addr;
                    wdata_d = lsu.i_wdata;
                    if (req_legal && req_aligned) begin
                        state_d = S_BUS;
`ifdef LSU_TIMEOUT_EN
                        cnt_d   = CNT_W'(TIMEOUT - 1);
`endif
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_BUS: begin
                if (lsu.i_bus_ready) begin
                    state_d = S_DONE;
                    if (!we_q) rdata_d = rd_ext;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            mode_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Bus fields come from latched request state, so they stay stable for the whole BUS phase.
    assign bus_valid       = (state_q == S_BUS);
    assign lsu.o_bus_valid = bus_valid;
    assign lsu.o_bus_we    = bus_valid & we_q;
    assign lsu.o_bus_addr  = bus_valid ? {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}} : '0;
    assign lsu.o_bus_be    = bus_valid ? (be_base << off) : '0;
    assign lsu.o_bus_wdata = bus_valid ? (wdata_q << {off, 3'b000}) : '0;
    assign lsu.o_busy      = (state_q != S_IDLE);
    assign lsu.o_done      = (state_q == S_DONE);
    assign lsu.o_err       = err_q;
    assign lsu.o_rdata     = rdata_q;
endmodule

// File: doc/lsu_multicycle.md
LSU_MULTICYCLE -- requirements
Module: lsu_multicycle

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum number of cycles to wait for i_bus_ready.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port i_req  input  1  start an access; sampled only in IDLE.
REQ-007 SHALL have port i_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port i_mode  input  3  RV funct3 width/sign code.
REQ-009 SHALL have ports i_addr  input  ADDR_W  byte address, and i_wdata  input  XLEN  store data, right-aligned.
REQ-010 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port o_done  output  1  single-cycle completion pulse.
REQ-012 SHALL have ports o_err  output  1  error flag qualified by o_done, and o_rdata  output  XLEN  extended load result.
REQ-013 SHALL have bus ports:
- o_bus_valid  output  1
- o_bus_we  output  1
- o_bus_addr  output  ADDR_W  XLEN/8-aligned address
- o_bus_wdata  output  XLEN  lane-shifted data
- o_bus_be  output  XLEN/8  byte enables
- i_bus_ready  input  1
- i_bus_rdata  input  XLEN

Function
REQ-014 SHALL implement FSM IDLE, BUS, DONE; IDLE->BUS on i_req with a legal, aligned access; BUS->DONE on the cycle i_bus_ready is high; DONE->IDLE unconditionally.
REQ-015 SHALL latch i_we, i_mode, i_addr and i_wdata on acceptance; input changes while o_busy is high have no effect.
REQ-016 SHALL hold o_bus_valid high for exactly the cycles spent in BUS, with bus address, data, enables and we held stable throughout.
REQ-017 SHALL give latency: i_req in cycle 0, o_bus_valid in cycle 1, i_bus_ready in cycle k>=1, o_done in cycle k+1, back in IDLE at k+2.
REQ-018 SHALL decode modes:
- 000 = B; 001 = H; 010 = W; 100 = BU; 101 = HU.
- 011 = D, legal only when XLEN=64.
- 110 = WU, legal only when XLEN=64 and only for loads.
- Stores accept only B, H, W and D.
- Every other combination is illegal.
REQ-019 SHALL treat the access as misaligned when the address is not a multiple of its access size.
REQ-020 SHALL route an illegal or misaligned request IDLE->DONE directly, with o_err=1, no o_bus_valid assertion and o_rdata unchanged.
REQ-021 SHALL form the bus address from i_addr with its low log2(XLEN/8) bits cleared.
REQ-022 SHALL set o_bus_be to size-many ones shifted left by the address offset, and o_bus_wdata to the store data shifted left by 8*offset.
REQ-023 SHALL, on a load, shift i_bus_rdata right by 8*offset, then sign-extend (B, H, W) or zero-extend (BU, HU, WU) to XLEN, and register the result into o_rdata on the BUS->DONE edge.
REQ-024 SHALL hold o_rdata until the next successful load completes; stores and errors do not modify it.
REQ-025 SHALL register o_done and o_err so that they are high only in DONE.
REQ-026 SHALL ignore i_bus_ready outside BUS.
REQ-027 SHALL ignore an i_req asserted in DONE; a new request is accepted no earlier than the next IDLE cycle.

Reset
REQ-028 SHALL, while rst=0 at a clock edge, force state IDLE, all outputs 0, o_rdata 0 and the timeout counter 0, including mid-transaction; o_bus_valid is 0 in the cycle after that edge.

Configuration
REQ-029 SHALL, when macro LSU_TIMEOUT_EN is defined, count cycles in BUS; when TIMEOUT consecutive cycles pass without i_bus_ready, it moves BUS->DONE with o_err=1 and o_rdata unchanged.
REQ-030 SHALL, when LSU_TIMEOUT_EN is undefined, omit the counter and wait in BUS indefinitely; parameter TIMEOUT is then unused.

Verification
REQ-031 SHALL cover: XLEN=32, load LB at 0x1003, ready held high, i_bus_rdata=0x80AABBCC -> o_bus_addr=0x1000, o_bus_be=1000, o_done in cycle 2, o_rdata=0xFFFFFF80, o_err=0.
REQ-032 SHALL cover: store SH at 0x2002, i_wdata=0x1234ABCD, ready after 3 wait cycles -> o_bus_wdata=0xABCD0000, o_bus_be=1100, valid high for 4 cycles, o_done in cycle 5.
REQ-033 SHALL cover: LW at 0x3001 -> o_done and o_err in cycle 1, o_bus_valid never high, o_rdata unchanged.
REQ-034 SHALL cover: XLEN=64, LWU at 0x4004, i_bus_rdata=0xF0000001_00000000 -> o_bus_be=0xF0, o_rdata=0x00000000_F0000001.
REQ-035 SHALL cover: LSU_TIMEOUT_EN defined with TIMEOUT=4, ready never asserted -> o_err=1 with o_done in cycle 5; with the macro undefined, still busy at cycle 100.
REQ-036 SHALL cover: rst=0 in the second BUS cycle -> o_bus_valid=0 and o_busy=0 in the cycle after the edge, and a request issued after release completes normally.
